// File: rtl/icache_pkg.sv
// Shared types, address-map constants and geometry helpers for the line instruction cache.
package icache_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle,
        StHitResp,
        StMissReq,
        StRefill,
        StUncWait,
        StResp
    } state_t;

    // kseg0 is cached, kseg1 is uncached; both map onto physical 0x0000_0000 upwards
    localparam logic [31:0] KSEG0_BASE  = 32'h8000_0000;
    localparam logic [31:0] KSEG0_LIMIT = 32'h9FFF_FFFF;
    localparam logic [31:0] KSEG1_BASE  = 32'hA000_0000;
    localparam logic [31:0] KSEG1_LIMIT = 32'hBFFF_FFFF;

    function automatic int unsigned offset_width(int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned index_width(int unsigned sets);
        return $clog2(sets);
    endfunction

    // Two byte-offset bits sit below the word offset
    function automatic int unsigned tag_width(int unsigned line_words, int unsigned sets);
        return 30 - offset_width(line_words) - index_width(sets);
    endfunction

    function automatic logic is_kseg0(logic [31:0] va);
        return (va >= KSEG0_BASE) && (va <= KSEG0_LIMIT);
    endfunction

    function automatic logic is_kseg1(logic [31:0] va);
        return (va >= KSEG1_BASE) && (va <= KSEG1_LIMIT);
    endfunction

    // Fixed segment translation; anything outside kseg0/kseg1 passes through
    function automatic logic [31:0] to_phys(logic [31:0] va);
        if (is_kseg0(va)) begin
            return va - KSEG0_BASE;
        end
        if (is_kseg1(va)) begin
            return va - KSEG1_BASE;
        end
        return va;
    endfunction

endpackage

// File: rtl/inst_cache_line_if.sv
// Fetch-side and bus-side handshake bundle of the line instruction cache.
interface inst_cache_line_if;

    logic        cache_call_begin;
    logic [31:0] pc;
    logic        cache_return_ready;
    logic [31:0] cache_return_instruction;

    logic        inst_interface_call_begin;
    logic [31:0] inst_interface_addr;
    logic [7:0]  inst_interface_burst_len;
    logic        inst_interface_return_ready;
    logic [31:0] inst_interface_rdata;

    // Cache side
    modport slave (
        input  cache_call_begin,
        input  pc,
        output cache_return_ready,
        output cache_return_instruction,
        output inst_interface_call_begin,
        output inst_interface_addr,
        output inst_interface_burst_len,
        input  inst_interface_return_ready,
        input  inst_interface_rdata
    );

    // CPU fetch stage plus bus model side
    modport master (
        output cache_call_begin,
        output pc,
        input  cache_return_ready,
        input  cache_return_instruction,
        input  inst_interface_call_begin,
        input  inst_interface_addr,
        input  inst_interface_burst_len,
        output inst_interface_return_ready,
        output inst_interface_rdata
    );

endinterface

// File: rtl/icache_data_ram.sv
// Instruction data store: one synchronous write port, one asynchronous read port.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SETS       = 128
) (
    input  logic                                                         clk,
    input  logic                                                         we,
    input  logic [index_width(SETS)+offset_width(LINE_WORDS)-1:0]        waddr,
    input  logic [31:0]                                                  wdata,
    input  logic [index_width(SETS)+offset_width(LINE_WORDS)-1:0]        raddr,
    output logic [31:0]                                                  rdata
);

    localparam int unsigned DEPTH = SETS * LINE_WORDS;

    logic [31:0] mem [DEPTH];

    // Refill beats land here; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_cache_line.sv
// Direct-mapped, line-based instruction cache with burst refill, kseg1 bypass and
// global invalidate.
module inst_cache_line
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SETS       = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              invalidate,
    inst_cache_line_if.slave  bus
);

    localparam int unsigned OFFSET_W = offset_width(LINE_WORDS);
    localparam int unsigned INDEX_W  = index_width(SETS);
    localparam int unsigned TAG_W    = tag_width(LINE_WORDS, SETS);
    localparam int unsigned RAM_AW   = INDEX_W + OFFSET_W;

    localparam logic [7:0]          REFILL_LEN = 8'(LINE_WORDS - 1);
    localparam logic [OFFSET_W-1:0] LAST_BEAT  = OFFSET_W'(LINE_WORDS - 1);

    state_t              state;
    logic [SETS-1:0]     valid;
    logic [TAG_W-1:0]    tag_array [SETS];

    logic [INDEX_W-1:0]  lat_index;
    logic [OFFSET_W-1:0] lat_offset;
    logic [TAG_W-1:0]    lat_tag;
    logic                lat_uncached;
    logic [OFFSET_W-1:0] beat_cnt;
    logic [31:0]         crit_word;
    logic                pending_inv;

    logic                resp_ready;
    logic [31:0]         resp_instr;
    logic                call_begin;
    logic [31:0]         call_addr;
    logic [7:0]          call_len;

    logic [31:0]         req_paddr;
    logic                req_uncached;
    logic [OFFSET_W-1:0] req_offset;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic                req_hit;

    logic                beat_fire;
    logic                last_beat;
    logic                crit_beat;
    logic                inv_any;
    logic [31:0]         ram_rdata;

    // Decode the incoming fetch; an invalidate in the same cycle forces a miss
    always_comb begin
        req_paddr    = to_phys(bus.pc);
        req_uncached = is_kseg1(bus.pc);
        req_offset   = req_paddr[OFFSET_W+1:2];
        req_index    = req_paddr[INDEX_W+OFFSET_W+1:OFFSET_W+2];
        req_tag      = req_paddr[31:INDEX_W+OFFSET_W+2];
        req_hit      = !req_uncached && !invalidate && valid[req_index] &&
                       (tag_array[req_index] == req_tag);
    end

    assign beat_fire = enable && !reset && (state == StRefill) && bus.inst_interface_return_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign crit_beat = (beat_cnt == lat_offset);
    assign inv_any   = pending_inv || invalidate;

    icache_data_ram #(
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS)
    ) u_data_ram (
        .clk   (clk),
        .we    (beat_fire),
        .waddr ({lat_index, beat_cnt}),
        .wdata (bus.inst_interface_rdata),
        .raddr (RAM_AW'({req_index, req_offset})),
        .rdata (ram_rdata)
    );

    // Tag is written with the final beat; a pending invalidate only withholds the valid bit
    always_ff @(posedge clk) begin
        if (beat_fire && last_beat) begin
            tag_array[lat_index] <= lat_tag;
        end
    end

    // Controller FSM with registered, single-cycle output pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            valid        <= '0;
            lat_index    <= '0;
            lat_offset   <= '0;
            lat_tag      <= '0;
            lat_uncached <= 1'b0;
            beat_cnt     <= '0;
            crit_word    <= '0;
            pending_inv  <= 1'b0;
            resp_ready   <= 1'b0;
            resp_instr   <= '0;
            call_begin   <= 1'b0;
            call_addr    <= '0;
            call_len     <= '0;
        end else if (enable) begin
            resp_ready <= 1'b0;
            resp_instr <= '0;
            call_begin <= 1'b0;
            call_addr  <= '0;
            call_len   <= '0;

            unique case (state)
                StIdle: begin
                    if (invalidate) begin
                        valid <= '0;
                    end
                    if (bus.cache_call_begin) begin
                        lat_index    <= req_index;
                        lat_offset   <= req_offset;
                        lat_tag      <= req_tag;
                        lat_uncached <= req_uncached;
                        beat_cnt     <= '0;
                        if (req_hit) begin
                            resp_ready <= 1'b1;
                            resp_instr <= ram_rdata;
                            state      <= StHitResp;
                        end else begin
                            call_begin <= 1'b1;
                            state      <= StMissReq;
                            if (req_uncached) begin
                                call_addr <= req_paddr;
                                call_len  <= 8'd0;
                            end else begin
                                call_addr <= {req_paddr[31:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
                                call_len  <= REFILL_LEN;
                            end
                        end
                    end
                end

                StHitResp: begin
                    state <= StIdle;
                    if (inv_any) begin
                        valid       <= '0;
                        pending_inv <= 1'b0;
                    end
                end

                StMissReq: begin
                    if (invalidate) begin
                        pending_inv <= 1'b1;
                    end
                    state <= lat_uncached ? StUncWait : StRefill;
                end

                StRefill: begin
                    if (invalidate) begin
                        pending_inv <= 1'b1;
                    end
                    if (bus.inst_interface_return_ready) begin
                        beat_cnt <= beat_cnt + OFFSET_W'(1);
                        if (crit_beat) begin
                            crit_word <= bus.inst_interface_rdata;
                        end
                        if (last_beat) begin
                            valid[lat_index] <= !inv_any;
                            resp_ready       <= 1'b1;
                            resp_instr       <= crit_beat ? bus.inst_interface_rdata : crit_word;
                            state            <= StResp;
                        end
                    end
                end

                StUncWait: begin
                    if (invalidate) begin
                        pending_inv <= 1'b1;
                    end
                    if (bus.inst_interface_return_ready) begin
                        resp_ready <= 1'b1;
                        resp_instr <= bus.inst_interface_rdata;
                        state      <= StResp;
                    end
                end

                StResp: begin
                    state <= StIdle;
                    if (inv_any) begin
                        valid       <= '0;
                        pending_inv <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.cache_return_ready        = resp_ready;
    assign bus.cache_return_instruction  = resp_instr;
    assign bus.inst_interface_call_begin = call_begin;
    assign bus.inst_interface_addr       = call_addr;
    assign bus.inst_interface_burst_len  = call_len;

endmodule

// File: tb/tb_inst_cache_line.sv
// Bench for inst_cache_line: directed vector table, then randomized fetches against a
// set/tag reference model.
module tb_inst_cache_line;

    localparam int unsigned LW   = 8;
    localparam int unsigned SETS = 128;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic invalidate;

    always #5 clk = ~clk;

    inst_cache_line_if cif();

    inst_cache_line #(
        .LINE_WORDS (LW),
        .SETS       (SETS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .invalidate (invalidate),
        .bus        (cif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    // Backing memory: every word distinct, plus the boot vector word
    function automatic logic [31:0] mem_word(logic [31:0] pa);
        if (pa == 32'h1FC0_0000) return 32'h3C08_BFC0;
        return 32'h100 + (pa >> 2);
    endfunction

    // ---------------- reference model ----------------
    bit          model_valid [SETS];
    int unsigned model_tag   [SETS];

    function automatic bit model_uncached(logic [31:0] va);
        return (va >= 32'hA000_0000) && (va < 32'hC000_0000);
    endfunction

    function automatic logic [31:0] model_phys(logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    function automatic void model_clear();
        foreach (model_valid[i]) model_valid[i] = 1'b0;
    endfunction

    task automatic model_predict(input logic [31:0] va, input int stall_at, output bit e_call,
                                 output logic [31:0] e_addr, output logic [7:0] e_len,
                                 output logic [31:0] e_instr, output int e_lat);
        logic [31:0] pa = model_phys(va);
        bit unc = model_uncached(va);
        int unsigned idx = (pa / (LW * 4)) % SETS;
        int unsigned tg  = pa / (LW * 4 * SETS);
        int beats = unc ? 1 : int'(LW);
        e_call  = unc || !(model_valid[idx] && model_tag[idx] == tg);
        e_addr  = unc ? pa : pa - (pa % (LW * 4));
        e_len   = unc ? 8'd0 : 8'(LW - 1);
        e_instr = mem_word(pa);
        e_lat   = !e_call ? 1 : beats + 2 + ((stall_at >= 0 && stall_at < beats) ? 3 : 0);
    endtask

    task automatic model_apply(input logic [31:0] va, input bit e_call, input int inv_at,
                               input bit aborted);
        logic [31:0] pa = model_phys(va);
        bit unc = model_uncached(va);
        int unsigned idx = (pa / (LW * 4)) % SETS;
        int beats = unc ? 1 : int'(LW);
        bit inv = e_call && inv_at >= 0 && inv_at < beats;
        if (aborted || inv) model_clear();
        else if (e_call && !unc) begin
            model_valid[idx] = 1'b1;
            model_tag[idx]   = pa / (LW * 4 * SETS);
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        bit          ready;
        bit          call;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] instr;
        int          lat;
        bit          zero_bad;
        bit          frozen_bad;
        bit          stalled;
        bit          aborted;
        bit          rst_bad;
    } res_t;

    // One fetch, acting as CPU and bus; inv/stall/reset are keyed to a beat index (-1 = off)
    task automatic run_fetch(input logic [31:0] va, input int inv_at, input int stall_at,
                             input int reset_at, input bit noise, output res_t r);
        int nbeats = 0;
        int beat = 0;
        int stall_left = 0;
        bit en_prev = 1'b1;
        bit resetting = 1'b0;
        bit new_call;
        logic        p_ready = 1'b0, p_icb = 1'b0;
        logic [31:0] p_instr = '0, p_addr = '0;
        logic [7:0]  p_len = '0;
        r = '{default: 0};
        r.lat = -1;
        @(negedge clk);
        cif.cache_call_begin = 1'b1;
        cif.pc = va;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (resetting) begin
                if (cif.cache_return_ready || cif.cache_return_instruction != 0 ||
                    cif.inst_interface_call_begin || cif.inst_interface_addr != 0 ||
                    cif.inst_interface_burst_len != 0) r.rst_bad = 1'b1;
                r.aborted = 1'b1;
                break;
            end
            if (!en_prev && (cif.cache_return_ready !== p_ready ||
                             cif.cache_return_instruction !== p_instr ||
                             cif.inst_interface_call_begin !== p_icb ||
                             cif.inst_interface_addr !== p_addr ||
                             cif.inst_interface_burst_len !== p_len)) r.frozen_bad = 1'b1;
            if (!cif.cache_return_ready && cif.cache_return_instruction != 0) r.zero_bad = 1'b1;
            if (!cif.inst_interface_call_begin &&
                (cif.inst_interface_addr != 0 || cif.inst_interface_burst_len != 0))
                r.zero_bad = 1'b1;
            p_ready = cif.cache_return_ready;
            p_instr = cif.cache_return_instruction;
            p_icb   = cif.inst_interface_call_begin;
            p_addr  = cif.inst_interface_addr;
            p_len   = cif.inst_interface_burst_len;

            if (cif.cache_return_ready) begin
                r.ready = 1'b1;
                r.instr = cif.cache_return_instruction;
                r.lat   = cyc;
                break;
            end
            new_call = cif.inst_interface_call_begin;
            if (new_call) begin
                r.call = 1'b1;
                r.addr = cif.inst_interface_addr;
                r.len  = cif.inst_interface_burst_len;
                nbeats = int'(cif.inst_interface_burst_len) + 1;
            end

            // Requests and pc changes after acceptance must be ignored
            cif.cache_call_begin = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cif.pc = noise ? $urandom : va;
            cif.inst_interface_return_ready = 1'b0;
            cif.inst_interface_rdata = $urandom;
            invalidate = 1'b0;
            enable = 1'b1;
            if (stall_left > 0) begin
                enable = 1'b0;
                stall_left--;
            end else if (r.call && !new_call && beat < nbeats) begin
                if (beat == stall_at && !r.stalled) begin
                    r.stalled = 1'b1;
                    enable = 1'b0;
                    stall_left = 2;
                end else begin
                    cif.inst_interface_return_ready = 1'b1;
                    cif.inst_interface_rdata = mem_word(r.addr + 32'(4 * beat));
                    if (beat == inv_at) invalidate = 1'b1;
                    if (beat == reset_at) begin
                        reset = 1'b1;
                        resetting = 1'b1;
                    end
                    beat++;
                end
            end
            en_prev = enable;
        end
        reset = 1'b0;
        enable = 1'b1;
        invalidate = 1'b0;
        cif.cache_call_begin = 1'b0;
        cif.inst_interface_return_ready = 1'b0;
    endtask

    task automatic pulse_inv_idle();
        @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        model_clear();
    endtask

    task automatic check_fetch(string nm, res_t r, bit e_call, logic [31:0] e_addr,
                               logic [7:0] e_len, logic [31:0] e_instr, int e_lat);
        chk({nm, ".ready"}, 32'(r.ready), 32'd1);
        chk({nm, ".call"}, 32'(r.call), 32'(e_call));
        if (e_call) begin
            chk({nm, ".addr"}, r.addr, e_addr);
            chk({nm, ".len"}, 32'(r.len), 32'(e_len));
        end
        chk({nm, ".instr"}, r.instr, e_instr);
        chk({nm, ".latency"}, 32'(r.lat), 32'(e_lat));
        chk({nm, ".idle_zero"}, 32'(r.zero_bad), 32'd0);
        chk({nm, ".frozen"}, 32'(r.frozen_bad), 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] va;
        bit          inv_idle;
        int          inv_at;
        int          stall_at;
        int          reset_at;
        bit          e_call;
        logic [31:0] e_addr;
        logic [7:0]  e_len;
        logic [31:0] e_instr;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];
    res_t res;

    initial begin
        bit          m_call;
        logic [31:0] m_addr, m_instr;
        logic [7:0]  m_len;
        int          m_lat;

        vecs.push_back('{"miss_k0",     32'h8000_0010, 0, -1, -1, -1, 1, 32'h0000_0000, 8'd7, 32'h104, 10});
        vecs.push_back('{"hit_same",    32'h8000_001C, 0, -1, -1, -1, 0, 32'h0,         8'd0, 32'h107, 1});
        vecs.push_back('{"unc_boot",    32'hBFC0_0000, 0, -1, -1, -1, 1, 32'h1FC0_0000, 8'd0, 32'h3C08_BFC0, 3});
        vecs.push_back('{"unc_again",   32'hBFC0_0000, 0, -1, -1, -1, 1, 32'h1FC0_0000, 8'd0, 32'h3C08_BFC0, 3});
        vecs.push_back('{"hit_line0",   32'h8000_0000, 0, -1, -1, -1, 0, 32'h0,         8'd0, 32'h100, 1});
        vecs.push_back('{"conflict",    32'h8000_1000, 0, -1, -1, -1, 1, 32'h0000_1000, 8'd7, 32'h500, 10});
        vecs.push_back('{"evicted",     32'h8000_0000, 0, -1, -1, -1, 1, 32'h0000_0000, 8'd7, 32'h100, 10});
        vecs.push_back('{"inv_idle",    32'h8000_0010, 1, -1, -1, -1, 1, 32'h0000_0000, 8'd7, 32'h104, 10});
        vecs.push_back('{"inv_refill",  32'h8000_0020, 0,  2, -1, -1, 1, 32'h0000_0020, 8'd7, 32'h108, 10});
        vecs.push_back('{"after_inv1",  32'h8000_0020, 0, -1, -1, -1, 1, 32'h0000_0020, 8'd7, 32'h108, 10});
        vecs.push_back('{"after_inv0",  32'h8000_0010, 0, -1, -1, -1, 1, 32'h0000_0000, 8'd7, 32'h104, 10});
        vecs.push_back('{"stall",       32'h8000_0040, 0, -1,  4, -1, 1, 32'h0000_0040, 8'd7, 32'h110, 13});
        vecs.push_back('{"passthru",    32'h0000_0044, 0, -1, -1, -1, 0, 32'h0,         8'd0, 32'h111, 1});
        vecs.push_back('{"reset_mid",   32'h8000_0060, 0, -1, -1,  3, 1, 32'h0000_0060, 8'd7, 32'h118, 10});
        vecs.push_back('{"post_reset",  32'h8000_0060, 0, -1, -1, -1, 1, 32'h0000_0060, 8'd7, 32'h118, 10});
        vecs.push_back('{"reset_clr",   32'h0000_0044, 0, -1, -1, -1, 1, 32'h0000_0040, 8'd7, 32'h111, 10});

        reset = 1'b1;
        enable = 1'b1;
        invalidate = 1'b0;
        cif.cache_call_begin = 1'b0;
        cif.pc = '0;
        cif.inst_interface_return_ready = 1'b0;
        cif.inst_interface_rdata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready", 32'(cif.cache_return_ready), 32'd0);
        chk("rst.instr", cif.cache_return_instruction, 32'd0);
        chk("rst.call", 32'(cif.inst_interface_call_begin), 32'd0);
        chk("rst.addr", cif.inst_interface_addr, 32'd0);
        chk("rst.len", 32'(cif.inst_interface_burst_len), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].inv_idle) pulse_inv_idle();
            model_predict(vecs[i].va, vecs[i].stall_at, m_call, m_addr, m_len, m_instr, m_lat);
            run_fetch(vecs[i].va, vecs[i].inv_at, vecs[i].stall_at, vecs[i].reset_at, 1'b0, res);
            if (vecs[i].reset_at >= 0) begin
                chk({vecs[i].nm, ".aborted"}, 32'(res.aborted), 32'd1);
                chk({vecs[i].nm, ".outs_zero"}, 32'(res.rst_bad), 32'd0);
                chk({vecs[i].nm, ".call"}, 32'(res.call), 32'd1);
            end else begin
                check_fetch(vecs[i].nm, res, vecs[i].e_call, vecs[i].e_addr, vecs[i].e_len,
                            vecs[i].e_instr, vecs[i].e_lat);
            end
            model_apply(vecs[i].va, m_call, vecs[i].inv_at, res.aborted);
        end

        for (int k = 0; k < 200; k++) begin
            logic [31:0] va;
            logic [31:0] off;
            int region, inv_at, stall_at;
            region = int'($urandom_range(0, 2));
            off = $urandom_range(0, 32'h3FFF) & ~32'h3;
            va = (region == 0) ? 32'h8000_0000 + off : (region == 1) ? 32'hA000_0000 + off : off;
            inv_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            stall_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            if ($urandom_range(0, 19) == 0) pulse_inv_idle();
            model_predict(va, stall_at, m_call, m_addr, m_len, m_instr, m_lat);
            run_fetch(va, inv_at, stall_at, -1, 1'b1, res);
            check_fetch($sformatf("rand%0d", k), res, m_call, m_addr, m_len, m_instr, m_lat);
            model_apply(va, m_call, inv_at, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_cache_line.md
# inst_cache_line

Parametrised, direct-mapped, line-based instruction cache replacing the single-word instruction cache between the CPU fetch stage and the instruction bus interface. It adds multi-word line refill over a burst handshake, configurable line size and set count, an uncached bypass for kseg1, and a global invalidate. The CPU-facing and interface-facing handshakes keep their existing single-cycle ready-pulse style.

## Interface
- LINE_WORDS, 8: 32-bit words per line; power of two, 2..64
- SETS, 128: number of lines; power of two, 2..1024
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  0 = freeze all state and outputs
- invalidate  in  1  single-cycle pulse: clear all valid bits
- cache_call_begin  in  1  fetch request, sampled only in IDLE
- pc  in  32  virtual fetch address, word aligned
- cache_return_ready  out  1  one-cycle pulse: instruction valid
- cache_return_instruction  out  32  instruction, valid with ready, else 0
- inst_interface_call_begin  out  1  one-cycle pulse starting a bus read
- inst_interface_addr  out  32  physical start address, valid with call_begin, else 0
- inst_interface_burst_len  out  8  beats minus one: LINE_WORDS-1 refill, 0 uncached
- inst_interface_return_ready  in  1  one data beat valid this cycle
- inst_interface_rdata  in  32  beat data

## Operation
- Address split (physical): offset [OFFSET_W+1:2], index [INDEX_W+OFFSET_W+1:OFFSET_W+2], tag the remaining upper bits; OFFSET_W=log2(LINE_WORDS), INDEX_W=log2(SETS).
- Translation: 0x8000_0000..0x9FFF_FFFF subtract 0x8000_0000, cached; 0xA000_0000..0xBFFF_FFFF subtract 0xA000_0000, uncached; all other pc passed through unchanged, cached.
- States: IDLE, HIT_RESP, MISS_REQ, REFILL, UNC_WAIT, RESP.
- IDLE + call_begin: latch pc and physical address. Cached hit (valid[index] && tag match) -> HIT_RESP; cached miss -> MISS_REQ; uncached -> MISS_REQ with uncached flag set.
- HIT_RESP: ready=1, instruction = data[index][offset]; -> IDLE.
- MISS_REQ: call_begin=1; addr = line-aligned physical address (offset bits zero) with burst_len LINE_WORDS-1, or the exact word address with burst_len 0 if uncached; -> REFILL or UNC_WAIT.
- REFILL: each return_ready beat writes data[index][beat_cnt] and increments beat_cnt from 0; the beat whose beat_cnt equals the latched offset is captured as the critical word. On beat LINE_WORDS-1: write tag, set valid (unless an invalidate is pending), -> RESP.
- UNC_WAIT: first beat captured, arrays untouched, -> RESP.
- RESP: ready=1 with the captured word; -> IDLE.
- call_begin outside IDLE is ignored; pc changes after acceptance are ignored.
- invalidate in IDLE clears all valid bits the same cycle. In any other state it sets a pending flag; pending invalidate clears all valid bits on the RESP->IDLE transition, and the line being filled is not marked valid.
- enable=0: no state, counter, array or output change; the interface must not deliver beats while enable=0.
- Reset: state IDLE, valid all 0, beat_cnt 0, pending 0, all outputs 0. Data/tag arrays are not reset. Reset mid-refill abandons the fill with no line made valid.

## Timing
- Hit: request accepted in cycle 0, ready pulse in cycle 1, next request accepted in cycle 2.
- Miss: call_begin in cycle 1; ready one cycle after the final beat.
- Uncached: call_begin in cycle 1; ready one cycle after the single beat.
- Output registers are deasserted/zeroed in every cycle they are not asserted.

## Structure
- Package icache_pkg: state enum; KSEG0/KSEG1 base and limit constants; helper functions for OFFSET_W, INDEX_W, TAG_W.
- Sub-module icache_data_ram: SETS*LINE_WORDS x 32, one synchronous write port, one asynchronous read port. Tag array and valid flop vector stay in the top module.

## Test plan
Defaults LINE_WORDS=8, SETS=128.
- Reset, then pc=0x8000_0010: call_begin with addr 0x0000_0000 and burst_len 7; beats 0x100..0x107 -> ready with 0x104. Then pc=0x8000_001C -> ready in the next cycle with 0x107 and no interface call.
- pc=0xBFC0_0000: addr 0x1FC0_0000, burst_len 0, beat 0x3C08BFC0 -> ready with 0x3C08BFC0. Repeat the same pc -> a new interface call is issued.
- Fill 0x8000_0000, then 0x8000_1000 (same index, different tag) -> refill at 0x0000_1000. Then 0x8000_0000 -> misses again.
- Fill the line, pulse invalidate in IDLE, then access 0x8000_0010 -> miss. Pulse invalidate during REFILL -> that line also misses on its next access.
- enable=0 for 3 cycles mid-refill -> outputs frozen; ready and data identical to the uninterrupted case, delayed by 3 cycles.
- reset asserted on beat 3 of a refill -> all outputs 0 next cycle; a later access to that line performs a full refill.
